fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Multi-cycle control FSM for the instruction-fetch datapath (PC register, PC+4 adder, branch-target adder, next-PC mux).
- Requests each instruction word from instruction memory and latches it into an instruction register.
- Hands the instruction to decode over a valid/ready handshake.
- Produces the one-cycle PC-advance enable and the branch-taken select (B & Z) that drive the PC update, plus a fetch-timeout fault.

Parameters:
- TIMEOUT, 16, max FETCH cycles without imem_ack before fault (legal 1..255)
- BR_OP, 6'b000100, opcode (ir[31:26]) identifying a conditional branch
- CNT_W, 16, width of issued-instruction counter

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- run  in  1  level; enables fetching of new instructions
- imem_req  out  1  instruction-memory read request; address = current PC
- imem_ack  in  1  memory returns imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- ir  out  32  instruction register
- ir_valid  out  1  ir holds an un-issued instruction
- dec_ready  in  1  decode accepts ir this cycle
- br_done  in  1  execute has resolved the outstanding branch; B, Z valid
- B  in  1  branch instruction flag from execute
- Z  in  1  ALU zero flag from execute
- pc_en  out  1  PC load enable, one-cycle pulse
- pc_sel  out  1  next-PC select: 0 = PC+4, 1 = branch target
- busy  out  1  FSM not in IDLE or FAULT
- fault  out  1  sticky fetch-timeout error
- issue_count  out  CNT_W  instructions accepted by decode, wraps

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE.
  - ir, ir_valid, imem_req, pc_en, pc_sel, busy, fault, issue_count and the wait counter all go to 0.
  - Reset asserted mid-operation aborts immediately; no pending pc_en is produced.
- All outputs are registered or Moore-decoded from state. No combinational path from any input to any output.
- States: IDLE, FETCH, ISSUE, BRWAIT, PCUPD, FAULT.
- IDLE:
  - All control outputs are 0.
  - run=1 moves to FETCH on the next edge.
  - The first fetch after reset uses the PC as-is, with no PC update.
- FETCH:
  - imem_req=1.
  - The wait counter clears on entry and increments each cycle without ack.
  - imem_ack=1: ir<=imem_rdata, ir_valid<=1, move to ISSUE.
  - Wait counter reaches TIMEOUT-1 with no ack: move to FAULT.
  - If ack arrives in the same cycle as the timeout, ack wins.
- ISSUE:
  - ir and ir_valid are held stable.
  - On dec_ready=1: ir_valid<=0 and issue_count<=issue_count+1.
  - Then, if ir[31:26]==BR_OP, move to BRWAIT; otherwise taken<=0 and move to PCUPD.
- BRWAIT:
  - Waits for br_done.
  - On br_done=1: taken<=B&Z (sampled that cycle), move to PCUPD.
- PCUPD:
  - Exactly one cycle with pc_en=1 and pc_sel=taken.
  - Next state is FETCH if run=1, else IDLE.
  - The next imem_req therefore starts one cycle after pc_en, once the PC holds its new value.
- FAULT:
  - fault=1; imem_req, pc_en and ir_valid are 0.
  - Exits only on Reset.
- Ignored inputs:
  - imem_ack outside FETCH.
  - dec_ready outside ISSUE.
  - br_done outside BRWAIT.
- run deasserted mid-instruction: the current instruction completes through PCUPD, then the FSM goes to IDLE. No partial abort.
- pc_sel=0 whenever pc_en=0.
- busy=1 in FETCH, ISSUE, BRWAIT and PCUPD.
- Minimum throughput (ack in the first FETCH cycle, dec_ready already high): 3 cycles per non-branch instruction.
- issue_count wraps modulo 2^CNT_W with no saturation.

Test Plan:
- Reset 0→1, run=1, ack 1 cycle after req with rdata=32'h00221820, dec_ready=1:
  - ir=32'h00221820 and ir_valid=1 for one cycle.
  - issue_count=1.
  - pc_en pulses once with pc_sel=0.
  - imem_req reasserts on the cycle after pc_en.
- rdata=32'h10000003 (branch):
  - After issue, no pc_en until br_done.
  - br_done with B=1, Z=1 gives one pc_en with pc_sel=1.
  - Repeat with Z=0: pc_sel=0.
- dec_ready held 0 for 5 cycles in ISSUE:
  - ir stable and ir_valid=1 throughout.
  - issue_count unchanged, no pc_en, no imem_req.
- Timeout, TIMEOUT=16:
  - No ack: fault=1 after 16 FETCH cycles, imem_req=0, and fault stays set through run toggles until Reset.
  - Ack in the 16th FETCH cycle: no fault, ir loads.
- run dropped to 0 during BRWAIT:
  - br_done still produces a pc_en pulse.
  - FSM then goes to IDLE with busy=0 and no further imem_req.
  - run=1 resumes with FETCH.
- Reset asserted mid-ISSUE and mid-PCUPD:
  - All outputs 0 asynchronously, before the next clock edge.
  - issue_count=0, and no pc_en after Reset releases.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control FSM.
// Sequences one instruction at a time through four steps:
//   1. Request the word at the current PC and latch it into ir.
//   2. Offer ir to decode.
//   3. For a conditional branch, wait for execute to resolve it.
//   4. Pulse the PC-advance enable with the next-PC select.
// A fetch that never gets an ack trips a sticky fault. Only Reset clears it.
// Every output is a flop, so no input has a combinational path to an output.
module fetch_sequencer #(
    parameter int         TIMEOUT = 16,         // max FETCH cycles without ack (1..255)
    parameter logic [5:0] BR_OP   = 6'b000100,  // conditional-branch opcode in ir[31:26]
    parameter int         CNT_W   = 16          // issued-instruction counter width
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             run,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ir,
    output logic             ir_valid,
    input  logic             dec_ready,
    input  logic             br_done,
    input  logic             B,
    input  logic             Z,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             busy,
    output logic             fault,
    output logic [CNT_W-1:0] issue_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        ISSUE  = 3'd2,
        BRWAIT = 3'd3,
        PCUPD  = 3'd4,
        FAULT  = 3'd5
    } state_t;

    // Last wait-counter value before a missing ack becomes a fault.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state_reg;
    logic [7:0] wait_cnt_reg;

    // Main sequencer: next state and all registered outputs in one place.
    // Each output is set on the transition into the state where it must be
    // seen, which keeps every output a plain flop (Moore timing).
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            ir           <= '0;
            ir_valid     <= 1'b0;
            imem_req     <= 1'b0;
            pc_en        <= 1'b0;
            pc_sel       <= 1'b0;
            busy         <= 1'b0;
            fault        <= 1'b0;
            issue_count  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // The first fetch uses the PC as it stands; no PC update precedes it.
                    if (run) begin
                        state_reg    <= FETCH;
                        imem_req     <= 1'b1;
                        busy         <= 1'b1;
                        wait_cnt_reg <= '0;
                    end
                end

                FETCH: begin
                    // An ack is checked before the timeout, so an ack in the last allowed cycle wins.
                    if (imem_ack) begin
                        ir        <= imem_rdata;
                        ir_valid  <= 1'b1;
                        imem_req  <= 1'b0;
                        state_reg <= ISSUE;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        imem_req  <= 1'b0;
                        busy      <= 1'b0;
                        fault     <= 1'b1;
                        state_reg <= FAULT;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end

                ISSUE: begin
                    // ir stays put until decode takes it.
                    if (dec_ready) begin
                        ir_valid    <= 1'b0;
                        issue_count <= issue_count + 1'b1;
                        if (ir[31:26] == BR_OP) begin
                            state_reg <= BRWAIT;
                        end else begin
                            // A non-branch always falls through to PC+4.
                            pc_en     <= 1'b1;
                            pc_sel    <= 1'b0;
                            state_reg <= PCUPD;
                        end
                    end
                end

                BRWAIT: begin
                    // The branch is taken only when execute flags a branch and a zero result.
                    if (br_done) begin
                        pc_en     <= 1'b1;
                        pc_sel    <= B & Z;
                        state_reg <= PCUPD;
                    end
                end

                PCUPD: begin
                    // The PC loads during this cycle.
                    // Any following request is raised one cycle later, against the new PC.
                    pc_en  <= 1'b0;
                    pc_sel <= 1'b0;
                    if (run) begin
                        imem_req     <= 1'b1;
                        wait_cnt_reg <= '0;
                        state_reg    <= FETCH;
                    end else begin
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end

                FAULT: begin
                    // Sticky: only Reset leaves this state.
                    state_reg <= FAULT;
                end

                default: begin
                    // Unreachable encodings recover to a quiet IDLE.
                    state_reg <= IDLE;
                    imem_req  <= 1'b0;
                    ir_valid  <= 1'b0;
                    pc_en     <= 1'b0;
                    pc_sel    <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer.
// Expected values are worked out by hand from the intended cycle timing.
// The FSM advances on each rising edge, and the outputs are inspected on the following falling edge.
module tb_fetch_sequencer;

    localparam int CNT_W = 16;

    logic             Clock;
    logic             Reset;
    logic             run;
    logic             imem_req;
    logic             imem_ack;
    logic [31:0]      imem_rdata;
    logic [31:0]      ir;
    logic             ir_valid;
    logic             dec_ready;
    logic             br_done;
    logic             B;
    logic             Z;
    logic             pc_en;
    logic             pc_sel;
    logic             busy;
    logic             fault;
    logic [CNT_W-1:0] issue_count;

    int vectors     = 0;
    int miscompares = 0;

    fetch_sequencer #(
        .TIMEOUT (16),
        .BR_OP   (6'b000100),
        .CNT_W   (CNT_W)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .run         (run),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .ir          (ir),
        .ir_valid    (ir_valid),
        .dec_ready   (dec_ready),
        .br_done     (br_done),
        .B           (B),
        .Z           (Z),
        .pc_en       (pc_en),
        .pc_sel      (pc_sel),
        .busy        (busy),
        .fault       (fault),
        .issue_count (issue_count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // One comparison: count it, report it, and flag it if it differs.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Advance one clock; outputs are inspected on the falling edge that follows.
    task automatic step();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    // Called in FETCH: present an ack with the given word, then confirm it was latched.
    task automatic fetch_word(input logic [31:0] word, input string tag);
        imem_ack   = 1'b1;
        imem_rdata = word;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check_val({tag, " ir"}, ir, word);
        check_val({tag, " ir_valid"}, {31'd0, ir_valid}, 32'd1);
        check_val({tag, " imem_req off"}, {31'd0, imem_req}, 32'd0);
    endtask

    // Checks that every output is back at its reset value.
    task automatic check_all_zero(input string tag);
        check_val({tag, " ir"}, ir, 32'd0);
        check_val({tag, " ctl"}, {26'd0, imem_req, ir_valid, pc_en, pc_sel, busy, fault}, 32'd0);
        check_val({tag, " issue_count"}, {16'd0, issue_count}, 32'd0);
    endtask

    // Drives a branch through BRWAIT with the given B/Z flags and checks the PC pulse.
    task automatic branch_case(input logic bb, input logic zz, input logic [31:0] cnt_exp, input string tag);
        dec_ready = 1'b1;
        fetch_word(32'h1000_0003, tag);
        step(); // ISSUE -> BRWAIT
        check_val({tag, " issue_count"}, {16'd0, issue_count}, cnt_exp);
        for (int i = 0; i < 3; i++) begin
            check_val({tag, " no pc_en in BRWAIT"}, {30'd0, pc_en, imem_req}, 32'd0);
            check_val({tag, " busy in BRWAIT"}, {31'd0, busy}, 32'd1);
            step();
        end
        br_done = 1'b1;
        B = bb;
        Z = zz;
        step(); // BRWAIT -> PCUPD
        br_done = 1'b0;
        B = 1'b0;
        Z = 1'b0;
        check_val({tag, " pc_en"}, {31'd0, pc_en}, 32'd1);
        check_val({tag, " pc_sel"}, {31'd0, pc_sel}, {31'd0, bb & zz});
    endtask

    initial begin
        Reset      = 1'b0;
        run        = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        dec_ready  = 1'b0;
        br_done    = 1'b0;
        B          = 1'b0;
        Z          = 1'b0;

        @(negedge Clock);
        step();
        check_all_zero("reset");
        Reset = 1'b1;
        run   = 1'b1;

        // Basic non-branch instruction at full throughput.
        step(); // IDLE -> FETCH
        check_val("t1 imem_req", {31'd0, imem_req}, 32'd1);
        check_val("t1 busy", {31'd0, busy}, 32'd1);
        dec_ready = 1'b1;
        fetch_word(32'h0022_1820, "t1");
        step(); // ISSUE -> PCUPD
        check_val("t1 ir_valid cleared", {31'd0, ir_valid}, 32'd0);
        check_val("t1 issue_count", {16'd0, issue_count}, 32'd1);
        check_val("t1 pc_en/sel", {30'd0, pc_en, pc_sel}, 32'b10);
        check_val("t1 no req with pc_en", {31'd0, imem_req}, 32'd0);
        step(); // PCUPD -> FETCH
        check_val("t1 pc_en drop", {30'd0, pc_en, pc_sel}, 32'd0);
        check_val("t1 req after pc_en", {31'd0, imem_req}, 32'd1);

        // Branch, taken.
        branch_case(1'b1, 1'b1, 32'd2, "t2 taken");
        step();
        check_val("t2 back to fetch", {29'd0, imem_req, pc_en, pc_sel}, 32'b100);

        // Branch with Z=0, not taken.
        branch_case(1'b1, 1'b0, 32'd3, "t2 nottaken");
        step();
        check_val("t2b back to fetch", {29'd0, imem_req, pc_en, pc_sel}, 32'b100);

        // Decode stalls for 5 cycles.
        dec_ready = 1'b0;
        fetch_word(32'h0043_0820, "t3");
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("t3 ir stable", ir, 32'h0043_0820);
            check_val("t3 hold ctl", {28'd0, ir_valid, pc_en, imem_req, busy}, 32'b1001);
            check_val("t3 issue_count held", {16'd0, issue_count}, 32'd3);
        end
        dec_ready = 1'b1;
        step();
        check_val("t3 pc_en", {31'd0, pc_en}, 32'd1);
        check_val("t3 issue_count", {16'd0, issue_count}, 32'd4);
        step();

        // run dropped while waiting on a branch.
        fetch_word(32'h1000_0003, "t5");
        step(); // -> BRWAIT
        run = 1'b0;
        step();
        check_val("t5 busy in BRWAIT", {31'd0, busy}, 32'd1);
        br_done = 1'b1;
        B = 1'b1;
        Z = 1'b0;
        step();
        br_done = 1'b0;
        B = 1'b0;
        check_val("t5 pc_en still", {30'd0, pc_en, pc_sel}, 32'b10);
        step();
        for (int i = 0; i < 3; i++) begin
            check_val("t5 idle quiet", {29'd0, busy, imem_req, pc_en}, 32'd0);
            step();
        end
        run = 1'b1;
        step();
        check_val("t5 resume fetch", {30'd0, imem_req, busy}, 32'b11);
        check_val("t5 issue_count", {16'd0, issue_count}, 32'd5);

        // Ack arrives in the 16th FETCH cycle.
        for (int i = 0; i < 15; i++) step();
        check_val("t4b still waiting", {30'd0, imem_req, fault}, 32'b10);
        fetch_word(32'h0000_0020, "t4b");
        check_val("t4b no fault", {31'd0, fault}, 32'd0);
        step(); // -> PCUPD
        step(); // -> FETCH

        // Reset during ISSUE.
        dec_ready = 1'b0;
        fetch_word(32'h0065_2020, "t6a");
        #2 Reset = 1'b0;
        #1 check_all_zero("t6a async");
        step();
        run = 1'b0;
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("t6a no pc_en", {30'd0, pc_en, imem_req}, 32'd0);
        end

        // Reset during PCUPD.
        run = 1'b1;
        step();
        dec_ready = 1'b1;
        fetch_word(32'h0065_2020, "t6b");
        step();
        check_val("t6b in pcupd", {31'd0, pc_en}, 32'd1);
        #2 Reset = 1'b0;
        #1 check_all_zero("t6b async");
        step();
        run = 1'b0;
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("t6b no pc_en", {29'd0, pc_en, imem_req, busy}, 32'd0);
        end

        // Timeout with no ack.
        run = 1'b1;
        step();
        for (int i = 0; i < 15; i++) step();
        check_val("t4 before timeout", {30'd0, imem_req, fault}, 32'b10);
        step();
        check_val("t4 fault", {28'd0, fault, imem_req, busy, pc_en}, 32'b1000);
        for (int i = 0; i < 4; i++) begin
            run = i[0];
            imem_ack = 1'b1;
            step();
            check_val("t4 fault sticky", {28'd0, fault, imem_req, busy, pc_en}, 32'b1000);
        end
        imem_ack = 1'b0;
        #2 Reset = 1'b0;
        #1 check_val("t4 fault cleared", {31'd0, fault}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
